// File: rtl/input_cmd_array.sv
// input_cmd_array: N-channel button conditioner producing command pulses.
// Synchronises raw levels, then applies per-channel mode, pair lock and pause.
module input_cmd_array #(
    parameter int NUM_CH      = 6,
    parameter int TIMER_W     = 6,
    parameter int SYNC_STAGES = 2,
    parameter int PAIR_LOCK   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         raw,
    input  logic [2*NUM_CH-1:0]       cfg_mode,
    input  logic [TIMER_W*NUM_CH-1:0] cfg_delay,
    input  logic [TIMER_W*NUM_CH-1:0] cfg_period,
    output logic [NUM_CH-1:0]         cmd
);

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_DAS     = 2'd1,
        MODE_REPEAT  = 2'd2,
        MODE_LEVEL   = 2'd3
    } mode_e;

    logic [NUM_CH-1:0]  s;
    logic [NUM_CH-1:0]  rise;
    logic [NUM_CH-1:0]  sup;
    logic [NUM_CH-1:0]  ho;
    logic [NUM_CH-1:0]  press;
    logic [NUM_CH-1:0]  prev_q;
    logic [NUM_CH-1:0]  phase_q, phase_d;
    logic [NUM_CH-1:0]  blocked_q, blocked_d;
    logic [NUM_CH-1:0]  cmd_q, cmd_d;
    logic [TIMER_W-1:0] cnt_q [NUM_CH];
    logic [TIMER_W-1:0] cnt_d [NUM_CH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = raw;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

            // Shift raw levels through the synchroniser chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= raw;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = s & ~prev_q;

    generate
        if (PAIR_LOCK != 0) begin : g_pair
            logic owner_q, owner_d;
            logic handover;
            logic own_held, oth_held;

            assign own_held = owner_q ? s[1] : s[0];
            assign oth_held = owner_q ? s[0] : s[1];

            // Owner is the latest presser of ch0/ch1; ch0 wins a tie
            always_comb begin
                owner_d  = owner_q;
                handover = 1'b0;
                if (rise[0]) begin
                    owner_d = 1'b0;
                end else if (rise[1]) begin
                    owner_d = 1'b1;
                end else if (!own_held && oth_held) begin
                    owner_d  = ~owner_q;
                    handover = 1'b1;
                end
            end

            // Non-owner is muted; a handover acts as a fresh press
            always_comb begin
                sup    = '0;
                ho     = '0;
                sup[0] = owner_d;
                sup[1] = ~owner_d;
                ho[0]  = handover & ~owner_d;
                ho[1]  = handover & owner_d;
            end

            // Owner register
            always_ff @(posedge clk) begin
                if (rst) begin
                    owner_q <= 1'b0;
                end else begin
                    owner_q <= owner_d;
                end
            end
        end else begin : g_nopair
            assign sup = '0;
            assign ho  = '0;
        end
    endgenerate

    assign press = (rise | ho) & ~blocked_q & ~sup;

    // Per-channel next state: pause, release, lockout, press, tick counting
    always_comb begin
        cmd_d     = '0;
        phase_d   = phase_q;
        blocked_d = blocked_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_e              mode;
            logic [TIMER_W-1:0] tgt;
            logic [TIMER_W:0]   nxt;
            mode = mode_e'(cfg_mode[2*i +: 2]);
            if (phase_q[i] || mode == MODE_REPEAT) begin
                tgt = cfg_period[TIMER_W*i +: TIMER_W];
            end else begin
                tgt = cfg_delay[TIMER_W*i +: TIMER_W];
            end
            if (tgt == '0) begin
                tgt = TIMER_W'(1);
            end
            nxt = {1'b0, cnt_q[i]} + (TIMER_W+1)'(1);
            if (!en) begin
                cnt_d[i]     = '0;
                phase_d[i]   = 1'b0;
                blocked_d[i] = s[i];
            end else if (!s[i]) begin
                cnt_d[i]     = '0;
                phase_d[i]   = 1'b0;
                blocked_d[i] = 1'b0;
            end else if (blocked_q[i] || sup[i]) begin
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end else if (press[i]) begin
                cmd_d[i]   = 1'b1;
                cnt_d[i]   = '0;
                phase_d[i] = (mode == MODE_REPEAT);
            end else begin
                unique case (mode)
                    MODE_LEVEL: cmd_d[i] = 1'b1;
                    MODE_DAS, MODE_REPEAT: begin
                        if (tick) begin
                            if (nxt >= {1'b0, tgt}) begin
                                cmd_d[i]   = 1'b1;
                                cnt_d[i]   = '0;
                                phase_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = nxt[TIMER_W-1:0];
                            end
                        end
                    end
                    MODE_ONESHOT: ;
                endcase
            end
        end
    end

    // Channel state and registered command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            phase_q   <= '0;
            blocked_q <= '0;
            cmd_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q    <= s;
            phase_q   <= phase_d;
            blocked_q <= blocked_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd = cmd_q;

endmodule

// File: doc/input_cmd_array.md
# input_cmd_array

Parametrised N-channel input conditioner that converts raw level button signals into single-cycle command pulses. It sits between the keyboard/button decode and the game FSM. It is the generalised successor of the fixed six-button input manager, adding:
- per-channel runtime mode and timing
- input synchronisers
- an opposing-pair lockout
- a pause/enable gate with re-arm on release

## Interface
Parameters:
- NUM_CH, 6: number of channels; must be ≥2 when PAIR_LOCK=1
- TIMER_W, 6: width of per-channel tick counter and of each delay/period field
- SYNC_STAGES, 2: synchroniser flops per raw input; 0 means raw is used directly
- PAIR_LOCK, 1: 1 makes channels 0 and 1 an opposing pair (left/right)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  single-cycle 60 Hz frame strobe
- en  in  1  1 = commands enabled; 0 = paused
- raw  in  NUM_CH  raw button levels, asynchronous
- cfg_mode  in  2*NUM_CH  per-channel mode; field i is bits [2i+1:2i]; 0 ONESHOT, 1 DAS, 2 REPEAT, 3 LEVEL
- cfg_delay  in  TIMER_W*NUM_CH  per-channel DAS delay in ticks
- cfg_period  in  TIMER_W*NUM_CH  per-channel repeat period in ticks
- cmd  out  NUM_CH  registered command pulses (level in LEVEL mode)

## Operation
- **Synchroniser:** s[i] is raw[i] after SYNC_STAGES flops.
- **Per-channel registers:** prev[i] (previous s), cnt[i] (TIMER_W), phase[i] (0 = initial delay, 1 = repeating), blocked[i].
- **Press event:** s=1, prev=0, not blocked and not suppressed.
- **Press action:** fire cmd, cnt←0. phase←0 in DAS; phase←1 in REPEAT.
- **Counting:** on each tick while held and not suppressed, cnt←cnt+1.
- **Target:** delay in phase 0, period in phase 1. A field value of 0 is treated as 1.
- **Fire condition:** cnt+1 ≥ target. On fire, cmd pulses, cnt←0 and phase←1. The ≥ compare means a config reduced mid-hold fires on the next tick with no wrap.
- **Mode behaviour:**
  - ONESHOT: pulse on the press event only; counter idle.
  - DAS: pulse on press, then on the delay-th tick after the press, then every period-th tick.
  - REPEAT: pulse on press, then every period-th tick; delay is ignored.
  - LEVEL: cmd[i] = s[i] & ~blocked & ~suppressed, registered; counter idle.
- **Release (s=0):** cnt←0, phase←0, blocked←0, no pulse.
- **Press/tick collision:** a tick in the same cycle as the press event is not counted.
- **Pair lock (PAIR_LOCK=1):**
  - The owner is the most recently pressed of channels 0 and 1. The other channel is suppressed: no cmd, counter held at 0.
  - If both press in the same cycle, channel 0 owns.
  - When the owner releases while the other is still held, the other becomes owner. This counts as a press event in that cycle: pulse, counter restart.
- **Pause (en=0):**
  - All cmd are 0 from the next cycle; all cnt/phase are cleared.
  - Any channel with s=1 gets blocked←1.
  - A blocked channel produces nothing until it releases. A button held across resume therefore never fires.
  - Presses occurring while en=0 are also blocked.
- **Config:** cfg_* is sampled every cycle, unregistered. Mode changes mid-hold take effect immediately; cnt is kept.

## Timing
- **Reset:** cmd=0, and sync flops, prev, cnt, phase, blocked and owner (=0) are all 0. Reset mid-hold produces a fresh press event SYNC_STAGES+1 cycles after rst deasserts if the button is still held.
- **Press latency:** raw rising (stable) → cmd pulse SYNC_STAGES+1 clk edges later. This is 3 cycles at default.
- **Pulse width:** exactly one clk cycle, except in LEVEL mode.
- **Repeat latency:** a repeat pulse is asserted in the cycle after the qualifying tick cycle.
- **Independence:** channels are independent except for the channel 0/1 lockout.

## Test plan
- **DAS repeat:** ch0 DAS, delay=16, period=6, hold raw[0] for 40 ticks → pulses at press+3 cycles, after tick 16, 22, 28, 34, 40; nothing after release.
- **ONESHOT and delay=0:** ch3 ONESHOT, hold 100 ticks → exactly 1 pulse. Ch2 REPEAT period=2 → pulses at press, then every 2nd tick. Delay=0 behaves as 1.
- **Pair lock:** hold ch0, 5 ticks later press ch1 → ch1 pulses and ch0 is silent. Release ch1 → ch0 pulses next cycle and restarts its delay. Simultaneous press of both → only ch0 fires.
- **Pause:** hold ch0 (DAS), drop en for 10 ticks, raise en while still held → no cmd until release and re-press; cmd=0 throughout the pause.
- **Config and LEVEL:** ch1 LEVEL mode → cmd[1] follows raw[1] delayed 3 cycles. Reduce ch0 period from 20 to 2 at cnt=10 → pulse on next tick.
- **Reset mid-hold:** assert rst for 1 cycle during a DAS hold → all outputs 0 next cycle; with raw still high, a new press pulse appears 3 cycles after rst falls.
